// File: rtl/fpr_i2f_if.sv
// Handshake bundle for the integer-to-float converter: input operand channel
// and result channel, each with valid/ready.
interface fpr_i2f_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/fpr_i2f.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter: normalises one bit
// per clock, then rounds (RNE or truncate) and holds the result until taken.
module fpr_i2f #(
  parameter bit RNE = 1'b1
) (
  input logic      clk,
  input logic      rst,
  fpr_i2f_if.slave bus
);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_INIT = 158;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_inexact_q, out_inexact_d;
  logic                sign_q, sign_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;

  logic [MANT_W-1:0]   mant_c;
  logic                guard_c, sticky_c, round_up_c;
  logic [MANT_W:0]     mant_sum_c;
  logic [EXP_W-1:0]    exp_rnd_c;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_inexact = out_inexact_q;

  // Rounding of the normalised magnitude; carry out of the mantissa bumps exp.
  always_comb begin
    mant_c     = mag_q[DATA_W-2:DATA_W-1-MANT_W];
    guard_c    = mag_q[7];
    sticky_c   = |mag_q[6:0];
    round_up_c = RNE && guard_c && (sticky_c || mant_c[0]);
    mant_sum_c = {1'b0, mant_c} + (MANT_W+1)'(round_up_c);
    exp_rnd_c  = mant_sum_c[MANT_W] ? exp_q + EXP_W'(1) : exp_q;
  end

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    sign_d        = sign_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d     = bus.in_signed & bus.in_data[DATA_W-1];
          mag_d      = sign_d ? (~bus.in_data + DATA_W'(1)) : bus.in_data;
          exp_d      = EXP_W'(EXP_INIT);
          in_ready_d = 1'b0;
          // Zero skips normalisation and is always +0.
          if (mag_d == '0) begin
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_data_d    = '0;
            out_inexact_d = 1'b0;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[DATA_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[DATA_W-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        out_data_d    = {sign_q, exp_rnd_c, mant_sum_c[MANT_W-1:0]};
        out_inexact_d = guard_c | sticky_c;
        out_valid_d   = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
      sign_q        <= 1'b0;
      mag_q         <= '0;
      exp_q         <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
      sign_q        <= sign_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
    end
  end
endmodule

// File: doc/fpr_i2f.md
# fpr_i2f

Multi-cycle integer-to-IEEE-754 single-precision converter. Accepts a 32-bit signed or unsigned integer over a valid/ready handshake, normalises it one bit per clock, rounds, and presents the packed float on a second valid/ready handshake. It produces the operands consumed by `fpr_add`, so integer sources can feed the floating-point datapath.

## Interface
- `RNE`, default 1: 1 selects round-to-nearest-even; 0 selects truncate toward zero.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset is asynchronous and active-high.
- `in_valid` input 1: `in_data` and `in_signed` are valid.
- `in_ready` output 1: the block can accept input. High only in IDLE.
- `in_data` input 32: integer operand.
- `in_signed` input 1: 1 treats `in_data` as two's complement; 0 treats it as unsigned.
- `out_valid` output 1: `out_data` and `out_inexact` are valid.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output 32: result as {sign, exp[7:0], mant[22:0]}.
- `out_inexact` output 1: the result differs from the exact value (guard or sticky bit was nonzero).

## Operation
- **States:** IDLE, NORM, ROUND, DONE.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`, register the following:
  - `sign = in_signed & in_data[31]`
  - `mag = sign ? -in_data : in_data` as a 32-bit unsigned value. 0x80000000 signed yields mag 0x80000000.
  - `exp = 158` (127+31).
- **Zero input:** if mag is 0, go directly to DONE with out_data = 0x00000000 and out_inexact = 0. Signed zero is never produced.
- **Nonzero input:** go to NORM.
- **NORM:** if mag[31]=1, go to ROUND. Otherwise set `mag <= mag << 1` and `exp <= exp - 1`. The block stays in NORM for lz+1 cycles, where lz is the leading-zero count (0..31).
- **ROUND:** compute the result from the normalised value.
  - `mant = mag[30:8]`, `G = mag[7]`, `S = |mag[6:0]`.
  - When RNE=1, round up if `G & (S | mant[0])`. When RNE=0, never round up.
  - A round-up carry out of mant sets mant to 0 and adds 1 to exp. Maximum exp is 159, so overflow is impossible.
  - Register `out_data = {sign, exp, mant}` and `out_inexact = G | S`, then go to DONE.
- **DONE:** `out_valid`=1. `out_data` and `out_inexact` hold stable until `out_ready`=1. On `out_valid && out_ready`, go to IDLE.
- **Width rules:** exp is 8 bits and mag is 32 bits. Rounding uses a 24-bit add on {1'b0, mant} to detect the carry.

## Timing
- **Reset values** (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_inexact=0.
- **Reset mid-conversion:** the in-flight operand is discarded with no output produced.
- **Latency:** acceptance at edge T.
  - Nonzero input: out_valid rises after edge T+lz+3.
  - Zero input: out_valid rises after edge T+1.
  - Best case is 3 cycles, worst case (lz=31) is 34 cycles.
- **Throughput:** one conversion in flight. `in_ready`=0 in NORM, ROUND and DONE.
- **Handshake ordering:** `in_ready` returns to 1 in the cycle after the output handshake. Input cannot be accepted in the same cycle as the output handshake.
- **Combinational paths:** `out_valid` and `in_ready` are registered-state decodes only, with no combinational path from `out_ready` or `in_valid`.
- **Backpressure:** `out_ready` held low holds DONE indefinitely with outputs unchanged.
- **Input sampling:** `in_data` and `in_signed` are sampled only on the accepting edge. Changes after that edge have no effect.

## Test plan
- **Signed 1:** in_signed=1, in_data=0x00000001 → out_data=0x3F800000, inexact=0, out_valid 34 cycles after acceptance. Signed 0xFFFFFFFF (-1) → 0xBF800000.
- **Most negative signed:** in_signed=1, in_data=0x80000000 → 0xCF000000, inexact=0, latency 3. Same data with in_signed=0 → 0x4F000000.
- **Rounding carry:** unsigned 0xFFFFFFFF → 0x4F800000 with inexact=1. With RNE=0 → 0x4F7FFFFF with inexact=1.
- **Ties to even:** 0x01000001 → 0x4B800000 (tie, even, round down). 0x01000003 → 0x4B800002 (tie, odd, round up). Both have inexact=1.
- **Zero:** 0x00000000 signed → 0x00000000 with out_valid one cycle after acceptance.
- **Backpressure and reset:**
  - Hold out_ready=0 for 10 cycles in DONE: outputs stay stable and in_ready=0.
  - Assert rst mid-NORM: out_valid=0 and in_ready=1 immediately.
  - A new input (0x00000002 → 0x40000000) then converts correctly.
